i2c_core: RTL and testbench

- Single-master I2C controller performing one random-access EEPROM-style transaction per `start` pulse.
- Supports either a byte write to, or a byte read from, a device and memory address.
- Generates SCL and drives the open-drain SDA line.
- Sits between a local control FSM and the external I2C bus pins.

---
 rtl/i2c_core_if.sv | 20 ++
 rtl/i2c_core.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_core.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_core_if.sv
// Local-side request/response bundle for i2c_core: transaction request fields in, last read byte out.
interface i2c_core_if;
  logic        start;
  logic        high_addr;
  logic [6:0]  dev_addr;
  logic [15:0] mem_addr;
  logic        rd_wr_en;
  logic [7:0]  data_wr;
  logic [7:0]  data_rd;

  modport master (
    output start, high_addr, dev_addr, mem_addr, rd_wr_en, data_wr,
    input  data_rd
  );

  modport slave (
    input  start, high_addr, dev_addr, mem_addr, rd_wr_en, data_wr,
    output data_rd
  );
endinterface

// File: rtl/i2c_core.sv
// Single-master I2C controller: one EEPROM-style random byte write or read per start pulse.
// Optional macro I2C_ACK_CHECK_EN: a slave NACK jumps straight to STOP instead of being ignored.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | bus idle, waiting for start
// START     | start condition (SDA falls while SCL high)
// DEV_W     | device address + write bit
// ACK       | slave acknowledge slot, SDA released
// MEM_HI    | memory address high byte (16-bit mode only)
// MEM_LO    | memory address low byte
// WR_DATA   | write data byte
// RESTART   | repeated start before read address
// DEV_R     | device address + read bit
// RD_DATA   | eight sampled data bits, SDA released
// MNACK     | master NACK, SDA released
// STOP      | stop condition (SDA rises while SCL high)
module i2c_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCL_FREQ = 50_000
) (
  input  logic        clk,
  input  logic        rstn,
  i2c_core_if.slave   host,
  output logic        scl,
  inout  wire         sda
);

  localparam int BIT_CYC = CLK_FREQ / SCL_FREQ;
  localparam int Q       = BIT_CYC / 4;
  localparam int TW      = $clog2(BIT_CYC);

  // Bit timer counts down from TC_LAST to 0; quarters decoded from its value.
  localparam logic [TW-1:0] TC_LAST = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] TQ0     = TW'(3 * Q);
  localparam logic [TW-1:0] TQ2     = TW'(2 * Q);
  localparam logic [TW-1:0] TSAMP   = TW'(Q - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_DEV_W   = 4'd2;
  localparam logic [3:0] S_ACK     = 4'd3;
  localparam logic [3:0] S_MEM_HI  = 4'd4;
  localparam logic [3:0] S_MEM_LO  = 4'd5;
  localparam logic [3:0] S_WR_DATA = 4'd6;
  localparam logic [3:0] S_RESTART = 4'd7;
  localparam logic [3:0] S_DEV_R   = 4'd8;
  localparam logic [3:0] S_RD_DATA = 4'd9;
  localparam logic [3:0] S_MNACK   = 4'd10;
  localparam logic [3:0] S_STOP    = 4'd11;

  logic [3:0]    state;
  logic [3:0]    ack_ret;
  logic [3:0]    ack_nx;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [7:0]    rd_byte;
  logic          sda_low;
  logic          sda_meta;
  logic          sda_sync;
  logic          scl_d;
  logic          sda_low_d;
  logic          scl_low_half;
  logic          in_q0;
  logic          is_byte;

  logic          cap_high;
  logic [6:0]    cap_dev;
  logic [15:0]   cap_mem;
  logic          cap_rd;
  logic [7:0]    cap_data;

`ifdef I2C_ACK_CHECK_EN
  logic          ack_bit;
`endif

  assign sda          = sda_low ? 1'b0 : 1'bz;
  assign host.data_rd = rd_byte;

  assign scl_low_half = (tmr >= TQ2);
  assign in_q0        = (tmr >= TQ0);
  assign is_byte      = (state == S_DEV_W) || (state == S_MEM_HI) || (state == S_MEM_LO) ||
                        (state == S_WR_DATA) || (state == S_DEV_R) || (state == S_RD_DATA);

  // Where to go once the acknowledge slot following the current byte is over.
  always_comb begin
    ack_nx = S_STOP;
    case (state)
      S_DEV_W:   ack_nx = cap_high ? S_MEM_HI : S_MEM_LO;
      S_MEM_HI:  ack_nx = S_MEM_LO;
      S_MEM_LO:  ack_nx = cap_rd ? S_RESTART : S_WR_DATA;
      S_DEV_R:   ack_nx = S_RD_DATA;
      default:   ack_nx = S_STOP;
    endcase
  end

  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state)
      S_IDLE:    ;
      S_START:   sda_low_d = !scl_low_half;
      S_RESTART: begin
        scl_d     = !in_q0;
        sda_low_d = !scl_low_half;
      end
      S_STOP: begin
        scl_d     = !in_q0;
        sda_low_d = scl_low_half;
      end
      S_DEV_W, S_MEM_HI, S_MEM_LO, S_WR_DATA, S_DEV_R: begin
        scl_d     = !scl_low_half;
        sda_low_d = !tx_sr[7];
      end
      default:   scl_d = !scl_low_half;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= S_IDLE;
      ack_ret  <= S_IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rd_byte  <= '0;
      scl      <= 1'b1;
      sda_low  <= 1'b0;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      cap_high <= 1'b0;
      cap_dev  <= '0;
      cap_mem  <= '0;
      cap_rd   <= 1'b0;
      cap_data <= '0;
`ifdef I2C_ACK_CHECK_EN
      ack_bit  <= 1'b0;
`endif
    end else begin
      scl      <= scl_d;
      sda_low  <= sda_low_d;
      sda_meta <= sda;
      sda_sync <= sda_meta;

      if (state == S_IDLE) begin
        if (host.start) begin
          cap_high <= host.high_addr;
          cap_dev  <= host.dev_addr;
          cap_mem  <= host.mem_addr;
          cap_rd   <= host.rd_wr_en;
          cap_data <= host.data_wr;
          state    <= S_START;
          tmr      <= TC_LAST;
        end
      end else begin
        if (tmr == TSAMP) begin
`ifdef I2C_ACK_CHECK_EN
          if (state == S_ACK) ack_bit <= sda_sync;
`endif
          if (state == S_RD_DATA) rx_sr <= {rx_sr[6:0], sda_sync};
        end

        if (tmr != '0) begin
          tmr <= tmr - 1'b1;
        end else begin
          tmr <= TC_LAST;
          if (is_byte) begin
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              tx_sr   <= {tx_sr[6:0], 1'b1};
            end else if (state == S_RD_DATA) begin
              rd_byte <= rx_sr;
              state   <= S_MNACK;
            end else begin
              ack_ret <= ack_nx;
              state   <= S_ACK;
            end
          end else begin
            case (state)
              S_START: begin
                state   <= S_DEV_W;
                tx_sr   <= {cap_dev, 1'b0};
                bit_cnt <= 3'd7;
              end
              S_ACK: begin
`ifdef I2C_ACK_CHECK_EN
                if (ack_bit) state <= S_STOP;
                else         state <= ack_ret;
`else
                state <= ack_ret;
`endif
                bit_cnt <= 3'd7;
                case (ack_ret)
                  S_MEM_HI:  tx_sr <= cap_mem[15:8];
                  S_MEM_LO:  tx_sr <= cap_mem[7:0];
                  S_WR_DATA: tx_sr <= cap_data;
                  default:   tx_sr <= 8'hFF;
                endcase
              end
              S_RESTART: begin
                state   <= S_DEV_R;
                tx_sr   <= {cap_dev, 1'b1};
                bit_cnt <= 3'd7;
              end
              S_MNACK: state <= S_STOP;
              default: begin
                state <= S_IDLE;
                tmr   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_core.sv
// Scoreboard bench for i2c_core: bus decoder + EEPROM-like slave model checked against a transaction-level model.
module tb_i2c_core;
  localparam int CLK_FREQ = 4_000_000;
  localparam int SCL_FREQ = 100_000;
  localparam int BIT_CYC  = CLK_FREQ / SCL_FREQ;

  localparam int T_ACK = 256;
  localparam int T_S   = 512;
  localparam int T_P   = 768;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic scl;
  logic slv_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_core_if bus ();

  i2c_core #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .host (bus.slave),
    .scl  (scl),
    .sda  (sda)
  );

  int         exp_q[$];
  int         dur_q[$];
  logic [7:0] rd_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] slv_rdval = 8'h00;
  logic [3:0] slv_nack  = 4'h0;
  logic [7:0] last_rd   = 8'h00;
  int         clear_req = 0;
  int         final_req = 0;

  // Transaction-level model: list the bus tokens a byte write/read must produce.
  task automatic issue(input bit rd, input bit hi, input logic [6:0] dev, input logic [15:0] mem,
                       input logic [7:0] wd, input logic [7:0] rv, input logic [3:0] nk);
    logic [7:0] wbytes[$];
    int  periods;
    int  idx;
    bit  aborted;
    bit  a;
    wbytes.push_back({dev, 1'b0});
    if (hi) wbytes.push_back(mem[15:8]);
    wbytes.push_back(mem[7:0]);
    if (!rd) wbytes.push_back(wd);
    exp_q.push_back(T_S);
    periods = 1;
    idx = 0;
    aborted = 0;
    foreach (wbytes[i]) begin
      if (!aborted) begin
        a = nk[idx];
        exp_q.push_back(int'(wbytes[i]));
        exp_q.push_back(T_ACK + int'(a));
        periods += 9;
        idx++;
`ifdef I2C_ACK_CHECK_EN
        if (a) aborted = 1;
`endif
      end
    end
    if (rd && !aborted) begin
      exp_q.push_back(T_S);
      exp_q.push_back(int'({dev, 1'b1}));
      a = nk[idx];
      exp_q.push_back(T_ACK + int'(a));
      periods += 10;
`ifdef I2C_ACK_CHECK_EN
      if (a) aborted = 1;
`endif
      if (!aborted) begin
        // A slave that did not ack its read address leaves the line released.
        last_rd = a ? 8'hFF : rv;
        exp_q.push_back(int'(last_rd));
        exp_q.push_back(T_ACK + 1);
        periods += 9;
      end
    end
    exp_q.push_back(T_P);
    periods += 1;
    dur_q.push_back((periods - 1) * BIT_CYC);
    rd_q.push_back(last_rd);
    slv_rdval = rv;
    slv_nack  = nk;
    @(negedge clk);
    bus.rd_wr_en  = rd;
    bus.high_addr = hi;
    bus.dev_addr  = dev;
    bus.mem_addr  = mem;
    bus.data_wr   = wd;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 * BIT_CYC && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3 * BIT_CYC) @(negedge clk);
  endtask

  // Monitor: decodes the bus, plays the slave, and compares against the queues.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       cs, cd;
  int         bitn = 0;
  int         byte_idx = 0;
  logic [7:0] shreg = 8'h00;
  bit         in_txn = 0;
  bit         rd_mode = 0;
  bit         first_byte = 0;
  bit         cur_nack = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         stall = 0;
  int         clear_ack = 0;
  int         final_ack = 0;

  task automatic check_tok(input int got);
    int want;
    checks++;
    stall = 0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bus_token: got %0h, expected queue empty", got);
    end else begin
      want = exp_q.pop_front();
      if (got != want) begin
        errors++;
        $display("FAIL bus_token: got %0h want %0h", got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    cs = scl;
    cd = sda;
    cyc++;
    if (clear_req != clear_ack) begin
      clear_ack = clear_req;
      exp_q.delete();
      dur_q.delete();
      rd_q.delete();
      in_txn = 0; bitn = 0; rd_mode = 0; first_byte = 0; slv_low = 1'b0; stall = 0;
      checks += 3;
      if (cs !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", cs); end
      if (cd !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want released", cd); end
      if (bus.data_rd !== 8'h00) begin errors++; $display("FAIL reset_data_rd: got %h want 00", bus.data_rd); end
    end else begin
      if (prev_scl && cs && prev_sda && !cd) begin
        check_tok(T_S);
        if (!in_txn) begin
          in_txn = 1; t0 = cyc; byte_idx = 0;
        end
        bitn = 0; rd_mode = 0; first_byte = 1;
      end else if (prev_scl && cs && !prev_sda && cd) begin
        check_tok(T_P);
        checks += 2;
        if (dur_q.size() == 0 || rd_q.size() == 0) begin
          errors++;
          $display("FAIL stop_unexpected: got stop with no pending transaction, want none");
        end else begin
          int dw;
          logic [7:0] rw;
          dw = dur_q.pop_front();
          rw = rd_q.pop_front();
          if (cyc - t0 != dw) begin
            errors++; $display("FAIL duration: got %0d want %0d clocks", cyc - t0, dw);
          end
          if (bus.data_rd !== rw) begin
            errors++; $display("FAIL data_rd: got %h want %h", bus.data_rd, rw);
          end
        end
        in_txn = 0; bitn = 0;
      end else if (!prev_scl && cs) begin
        bitn++;
        if (bitn <= 8) shreg = {shreg[6:0], cd};
        if (bitn == 8) check_tok(int'(shreg));
        if (bitn == 9) check_tok(T_ACK + int'(cd));
      end else if (prev_scl && !cs) begin
        if (bitn == 8) begin
          if (rd_mode) slv_low = 1'b0;
          else begin
            cur_nack = slv_nack[byte_idx[1:0]];
            slv_low  = !cur_nack;
            byte_idx++;
          end
        end else if (bitn == 9) begin
          slv_low = 1'b0;
          if (rd_mode) rd_mode = 0;
          else if (first_byte && shreg[0] && !cur_nack) begin
            rd_mode = 1;
            slv_low = !slv_rdval[7];
          end
          first_byte = 0;
          bitn = 0;
        end else if (rd_mode && bitn >= 1 && bitn <= 7) begin
          slv_low = !slv_rdval[7 - bitn];
        end
      end
      if (exp_q.size() != 0) stall++;
      if (stall > 60 * BIT_CYC) begin
        checks++; errors++;
        $display("FAIL timeout: got no bus token for %0d clocks, want progress", stall);
        exp_q.delete(); dur_q.delete(); rd_q.delete();
        stall = 0; in_txn = 0; bitn = 0; slv_low = 1'b0;
      end
    end
    if (final_req != final_ack) begin
      final_ack = final_req;
      checks++;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL leftover_tokens: got %0d pending want 0", exp_q.size());
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  initial begin
    bus.start     = 1'b1;
    bus.high_addr = 1'b0;
    bus.dev_addr  = 7'h55;
    bus.mem_addr  = 16'h1234;
    bus.rd_wr_en  = 1'b0;
    bus.data_wr   = 8'h77;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    clear_req++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    bus.start = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);

    issue(0, 0, 7'h51, 16'h00BB, 8'hFF, 8'h00, 4'h0);
    wait_done();

    // Busy: second start with altered inputs must not disturb the running write.
    issue(0, 1, 7'h51, 16'h12BB, 8'hFF, 8'h00, 4'h0);
    repeat (5 * BIT_CYC) @(negedge clk);
    bus.start = 1'b1; bus.dev_addr = 7'h22; bus.mem_addr = 16'hFFFF; bus.rd_wr_en = 1'b1; bus.data_wr = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    issue(1, 0, 7'h51, 16'h0034, 8'h00, 8'h5A, 4'h0);
    wait_done();
    issue(1, 1, 7'h3C, 16'hA5C3, 8'h00, 8'h81, 4'h0);
    wait_done();
    issue(0, 0, 7'h51, 16'h0010, 8'h42, 8'h00, 4'h1);
    wait_done();

    for (int n = 0; n < 10; n++) begin
      logic [3:0] nk;
      nk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      issue(1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), nk);
      wait_done();
    end

    // Abort mid-byte: reset while the master holds SDA low in DEV_W.
    issue(0, 0, 7'h51, 16'h00BB, 8'h11, 8'h00, 4'h0);
    repeat (2 * BIT_CYC + 5) @(negedge clk);
    rstn = 1'b1;
    last_rd = 8'h00;
    @(posedge clk); #1;
    clear_req++;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);

    issue(1, 0, 7'h2A, 16'h0099, 8'h00, 8'hC6, 4'h0);
    wait_done();

    final_req++;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
